// File: rtl/pcie_dllp_rx_decode.sv
// Receive-side DLLP assembler/decoder: collects 6-byte DLLPs, checks framing and decodes Ack/Nak, FC and other events.
// Optional CRC-16 checking over bytes 0-3 is enabled with `define PCIE_DLLP_CRC_CHECK_EN.
module pcie_dllp_rx_decode #(
  parameter logic [7:0]  VC_MASK        = 8'h01,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  output logic                      ack_valid,
  output logic                      nak_valid,
  output logic [11:0]               ack_seq,
  output logic                      fc_valid,
  output logic [1:0]                fc_phase,
  output logic [1:0]                fc_kind,
  output logic [2:0]                fc_vc,
  output logic [7:0]                fc_hdr,
  output logic [11:0]               fc_data,
  output logic                      other_valid,
  output logic [7:0]                other_type,
  output logic                      err_len,
  output logic                      err_type,
  output logic                      err_crc,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic {COLLECT, DISCARD} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] b0, b1, b2, b3;
  logic       accept, last_byte;
  logic       is_ack, is_nak, is_other, is_fc, vc_ok;
  logic [1:0] phase;
  logic       crc_bad, drop_event;

  assign s_axis_tready = !rst;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_byte     = (idx == 3'd5);

  // Type decode works on the stored byte0; byte0[3] is reserved for FC types.
  always_comb begin
    is_ack   = (b0 == 8'h00);
    is_nak   = (b0 == 8'h10);
    is_other = (b0 == 8'h20) || (b0 == 8'h21) || (b0 == 8'h23) ||
               (b0 == 8'h24) || (b0 == 8'h30);
    is_fc    = 1'b0;
    phase    = 2'd0;
    case (b0[7:4])
      4'h4, 4'h5, 4'h6: begin is_fc = 1'b1; phase = 2'd0; end
      4'hC, 4'hD, 4'hE: begin is_fc = 1'b1; phase = 2'd1; end
      4'h8, 4'h9, 4'hA: begin is_fc = 1'b1; phase = 2'd2; end
      default: ;
    endcase
    vc_ok = VC_MASK[b0[2:0]];
  end

`ifdef PCIE_DLLP_CRC_CHECK_EN
  logic [15:0] crc_q, crc_seed, crc_expect;
  logic [7:0]  crc_b4;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h100B : 16'h0000);
    end
    return r;
  endfunction

  assign crc_seed = (idx == 3'd0) ? 16'hFFFF : crc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q  <= 16'hFFFF;
      crc_b4 <= 8'h00;
    end else if (accept && state == COLLECT) begin
      if (idx < 3'd4)
        crc_q <= crc_step(crc_seed, s_axis_tdata);
      else if (idx == 3'd4)
        crc_b4 <= s_axis_tdata;
    end
  end

  // Transmitted CRC is the complemented remainder, bit-reversed within each byte.
  always_comb begin
    crc_expect = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      crc_expect[8+i] = ~crc_q[15-i];
      crc_expect[i]   = ~crc_q[7-i];
    end
  end

  assign crc_bad = ({crc_b4, s_axis_tdata} != crc_expect);
`else
  assign crc_bad = 1'b0;
`endif

  assign drop_event = accept && (state == COLLECT) &&
                      (last_byte ? (!s_axis_tlast || crc_bad ||
                                    !(is_ack || is_nak || is_other || (is_fc && vc_ok)))
                                 : s_axis_tlast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= 3'd0;
      b0          <= 8'h00;
      b1          <= 8'h00;
      b2          <= 8'h00;
      b3          <= 8'h00;
      ack_valid   <= 1'b0;
      nak_valid   <= 1'b0;
      ack_seq     <= 12'h000;
      fc_valid    <= 1'b0;
      fc_phase    <= 2'd0;
      fc_kind     <= 2'd0;
      fc_vc       <= 3'd0;
      fc_hdr      <= 8'h00;
      fc_data     <= 12'h000;
      other_valid <= 1'b0;
      other_type  <= 8'h00;
      err_len     <= 1'b0;
      err_type    <= 1'b0;
      err_crc     <= 1'b0;
    end else begin
      ack_valid   <= 1'b0;
      nak_valid   <= 1'b0;
      fc_valid    <= 1'b0;
      other_valid <= 1'b0;
      err_len     <= 1'b0;
      err_type    <= 1'b0;
      err_crc     <= 1'b0;
      if (accept) begin
        if (state == DISCARD) begin
          if (s_axis_tlast) begin
            state <= COLLECT;
            idx   <= 3'd0;
          end
        end else if (!last_byte) begin
          if (s_axis_tlast) begin
            err_len <= 1'b1;
            idx     <= 3'd0;
          end else begin
            case (idx)
              3'd0: b0 <= s_axis_tdata;
              3'd1: b1 <= s_axis_tdata;
              3'd2: b2 <= s_axis_tdata;
              3'd3: b3 <= s_axis_tdata;
              default: ;
            endcase
            idx <= idx + 3'd1;
          end
        end else begin
          // Byte 5: either the DLLP completes and is decoded, or it overran.
          idx <= 3'd0;
          if (!s_axis_tlast) begin
            err_len <= 1'b1;
            state   <= DISCARD;
          end else if (crc_bad) begin
            err_crc <= 1'b1;
          end else if (is_ack || is_nak) begin
            ack_valid <= is_ack;
            nak_valid <= is_nak;
            ack_seq   <= {b2[3:0], b3};
          end else if (is_fc) begin
            if (vc_ok) begin
              fc_valid <= 1'b1;
              fc_phase <= phase;
              fc_kind  <= b0[5:4];
              fc_vc    <= b0[2:0];
              fc_hdr   <= {b1[5:0], b2[7:6]};
              fc_data  <= {b2[3:0], b3};
            end
          end else if (is_other) begin
            other_valid <= 1'b1;
            other_type  <= b0;
          end else begin
            err_type <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop_event && (drop_cnt != {DROP_CNT_WIDTH{1'b1}}))
      drop_cnt <= drop_cnt + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_pcie_dllp_rx_decode.sv
// Directed self-checking bench for pcie_dllp_rx_decode; two instances share the byte stream to cover two VC masks.
module tb_pcie_dllp_rx_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;

  logic        tready, ack_valid, nak_valid, fc_valid, other_valid, err_len, err_type, err_crc;
  logic [11:0] ack_seq, fc_data;
  logic [1:0]  fc_phase, fc_kind;
  logic [2:0]  fc_vc;
  logic [7:0]  fc_hdr, other_type, drop_cnt;

  logic        m_tready, m_ack_valid, m_nak_valid, m_fc_valid, m_other_valid, m_err_len, m_err_type, m_err_crc;
  logic [11:0] m_ack_seq, m_fc_data;
  logic [1:0]  m_fc_phase, m_fc_kind;
  logic [2:0]  m_fc_vc;
  logic [7:0]  m_fc_hdr, m_other_type;
  logic [15:0] m_drop_cnt;

  int checks = 0;
  int failures = 0;
  int n_ack = 0, n_nak = 0, n_fc = 0, n_len = 0, n_type = 0;

  pcie_dllp_rx_decode #(.VC_MASK(8'h11), .DROP_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .ack_valid(ack_valid), .nak_valid(nak_valid), .ack_seq(ack_seq),
    .fc_valid(fc_valid), .fc_phase(fc_phase), .fc_kind(fc_kind), .fc_vc(fc_vc), .fc_hdr(fc_hdr),
    .fc_data(fc_data), .other_valid(other_valid), .other_type(other_type), .err_len(err_len),
    .err_type(err_type), .err_crc(err_crc), .drop_cnt(drop_cnt)
  );

  pcie_dllp_rx_decode #(.VC_MASK(8'h01), .DROP_CNT_WIDTH(16)) dut_m (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(m_tready),
    .s_axis_tlast(tlast), .ack_valid(m_ack_valid), .nak_valid(m_nak_valid), .ack_seq(m_ack_seq),
    .fc_valid(m_fc_valid), .fc_phase(m_fc_phase), .fc_kind(m_fc_kind), .fc_vc(m_fc_vc), .fc_hdr(m_fc_hdr),
    .fc_data(m_fc_data), .other_valid(m_other_valid), .other_type(m_other_type), .err_len(m_err_len),
    .err_type(m_err_type), .err_crc(m_err_crc), .drop_cnt(m_drop_cnt)
  );

  always #5 clk = ~clk;

  // Pulses last one cycle, so each is seen by exactly one falling edge.
  always @(negedge clk) begin
    n_ack  += int'(ack_valid);
    n_nak  += int'(nak_valid);
    n_fc   += int'(fc_valid);
    n_len  += int'(err_len);
    n_type += int'(err_type);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] dllpCrc(input logic [31:0] p);
    logic [15:0] c;
    logic [15:0] r;
    logic        bitv;
    c = 16'hFFFF;
    for (int k = 0; k < 32; k++) begin
      bitv = p[24 - 8 * (k / 8) + (k % 8)];
      c = {c[14:0], 1'b0} ^ ((c[15] ^ bitv) ? 16'h100B : 16'h0000);
    end
    r = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      r[8+i] = ~c[15-i];
      r[i]   = ~c[7-i];
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [63:0] bytes, input int n, input bit last_on_end, input bit keep);
    for (int k = 0; k < n; k++) begin
      tdata  = bytes[63 - 8 * k -: 8];
      tvalid = 1'b1;
      tlast  = last_on_end && (k == n - 1);
      @(posedge clk);
      #1;
    end
    if (!keep) begin
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic sendDllp(input logic [31:0] p, input logic [15:0] flip, input bit keep);
    applyStimulus({p, dllpCrc(p) ^ flip, 16'h0000}, 6, 1'b1, keep);
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int len0, ack0, nak0, fc0, type0;
  logic [15:0] mdrop0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tready", tready, 0);
    checkOutput("rst_drop", drop_cnt, 0);
    checkOutput("rst_ack_valid", ack_valid, 0);
    checkOutput("rst_ack_seq", ack_seq, 0);
    checkOutput("rst_fc_valid", fc_valid, 0);
    rst = 1'b0;
    #1;
    checkOutput("tready_up", tready, 1);

    sendDllp(32'h000005A7, 16'h0, 1'b0);
    checkOutput("ack_valid", ack_valid, 1);
    checkOutput("ack_seq", ack_seq, 12'h5A7);
    checkOutput("ack_nak_quiet", nak_valid, 0);
    settle(1);
    checkOutput("ack_pulse_end", ack_valid, 0);

    sendDllp(32'h443FC240, 16'h0, 1'b0);
    checkOutput("fc1_valid", fc_valid, 1);
    checkOutput("fc1_phase", fc_phase, 0);
    checkOutput("fc1_kind", fc_kind, 0);
    checkOutput("fc1_vc", fc_vc, 4);
    checkOutput("fc1_hdr", fc_hdr, 8'hFF);
    checkOutput("fc1_data", fc_data, 12'h240);
    checkOutput("fc1_drop", drop_cnt, 0);
    checkOutput("fc1_ack_seq_hold", ack_seq, 12'h5A7);
    checkOutput("vcmask_no_fc", m_fc_valid, 0);
    checkOutput("vcmask_drop", m_drop_cnt, 1);
    checkOutput("vcmask_no_err", {m_err_len, m_err_type}, 0);

    applyStimulus(64'h0000000000000000, 3, 1'b1, 1'b0);
    checkOutput("short_err_len", err_len, 1);
    checkOutput("short_drop", drop_cnt, 1);
    sendDllp(32'h10000001, 16'h0, 1'b0);
    checkOutput("nak_valid", nak_valid, 1);
    checkOutput("nak_ack_quiet", ack_valid, 0);
    checkOutput("nak_seq", ack_seq, 12'h001);
    checkOutput("nak_err_len_quiet", err_len, 0);

    settle(1);
    len0 = n_len;
    applyStimulus(64'h1122334455667788, 8, 1'b1, 1'b0);
    settle(1);
    checkOutput("long_one_err_len", n_len - len0, 1);
    checkOutput("long_drop", drop_cnt, 2);
    sendDllp(32'h20000000, 16'h0, 1'b0);
    checkOutput("other_valid", other_valid, 1);
    checkOutput("other_type", other_type, 8'h20);
    checkOutput("fc_hdr_hold", fc_hdr, 8'hFF);

    sendDllp(32'h70000000, 16'h0, 1'b0);
    checkOutput("bad_type_err", err_type, 1);
    checkOutput("bad_type_other", other_valid, 0);
    checkOutput("bad_type_drop", drop_cnt, 3);
    sendDllp(32'h98123456, 16'h0, 1'b0);
    checkOutput("ufc_valid", fc_valid, 1);
    checkOutput("ufc_phase", fc_phase, 2);
    checkOutput("ufc_kind", fc_kind, 1);
    checkOutput("ufc_vc", fc_vc, 0);
    checkOutput("ufc_hdr", fc_hdr, 8'h48);
    checkOutput("ufc_data", fc_data, 12'h456);
    checkOutput("ufc_vc0_other_mask", m_fc_valid, 1);
    sendDllp(32'h4B000000, 16'h0, 1'b0);
    checkOutput("vc3_filtered", fc_valid, 0);
    checkOutput("vc3_no_type_err", err_type, 0);
    checkOutput("vc3_drop", drop_cnt, 4);

    settle(1);
    ack0 = n_ack; nak0 = n_nak; fc0 = n_fc; len0 = n_len;
    sendDllp(32'h00000123, 16'h0, 1'b1);
    applyStimulus({32'h10000ABC, 32'h0}, 3, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_tready", tready, 0);
    checkOutput("midrst_drop", drop_cnt, 0);
    checkOutput("midrst_seq", ack_seq, 0);
    rst = 1'b0;
    sendDllp(32'hD0010203, 16'h0, 1'b0);
    checkOutput("ifc2_valid", fc_valid, 1);
    checkOutput("ifc2_phase", fc_phase, 1);
    checkOutput("ifc2_kind", fc_kind, 1);
    checkOutput("ifc2_hdr", fc_hdr, 8'h04);
    checkOutput("ifc2_data", fc_data, 12'h203);
    settle(1);
    checkOutput("b2b_ack_count", n_ack - ack0, 1);
    checkOutput("b2b_nak_count", n_nak - nak0, 0);
    checkOutput("b2b_fc_count", n_fc - fc0, 1);
    checkOutput("b2b_len_count", n_len - len0, 0);

    sendDllp(32'h90112233, 16'h0, 1'b0);
    checkOutput("crc_good_fc", fc_valid, 1);
    checkOutput("crc_good_kind", fc_kind, 1);
    checkOutput("crc_good_hdr", fc_hdr, 8'h44);
    checkOutput("crc_good_err", err_crc, 0);
    sendDllp(32'h90112233, 16'h0004, 1'b0);
`ifdef PCIE_DLLP_CRC_CHECK_EN
    checkOutput("crc_bad_err", err_crc, 1);
    checkOutput("crc_bad_fc", fc_valid, 0);
    checkOutput("crc_bad_drop", drop_cnt, 1);
`else
    checkOutput("crc_off_err", err_crc, 0);
    checkOutput("crc_off_fc", fc_valid, 1);
    checkOutput("crc_off_drop", drop_cnt, 0);
`endif

    settle(1);
    mdrop0 = m_drop_cnt;
    len0 = n_len;
    for (int i = 0; i < 260; i++)
      applyStimulus({8'hFF, 56'h0}, 1, 1'b1, 1'b1);
    tvalid = 1'b0;
    tlast  = 1'b0;
    settle(1);
    checkOutput("sat_drop", drop_cnt, 8'hFF);
    checkOutput("wide_drop", m_drop_cnt, mdrop0 + 16'd260);
    checkOutput("sat_len_count", n_len - len0, 260);
    type0 = n_type;
    sendDllp(32'h70000000, 16'h0, 1'b0);
    checkOutput("sat_type_err", err_type, 1);
    checkOutput("sat_hold", drop_cnt, 8'hFF);
    settle(1);
    checkOutput("sat_type_count", n_type - type0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
